mem_stage: RTL and testbench

- Memory-access pipeline stage of the 5-stage MIPS core. It sits directly downstream of the execute stage and upstream of write-back.
- Registers the execute-stage outputs and performs loads and stores over a req/gnt/rvalid data bus with wait states.
- Aligns byte, halfword and word lanes, and sign- or zero-extends load data.
- Stalls the pipeline while an access is outstanding, and provides forwarding data to the hazard logic.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_align.sv | 39 +++
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] regc_data;
    logic [4:0]  regc_addr;
    logic        regc_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        rd;
    logic        wr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        ld_sext;
    logic [31:0] inst;
    logic [31:0] pc;
  } pipe_t;

  // Unrecognised nonzero masks fall back to a full word access.
  function automatic size_e decode_size(input logic [3:0] mask);
    size_e size;
    case (mask)
      MASK_B:  size = SIZE_B;
      MASK_H:  size = SIZE_H;
      default: size = SIZE_W;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_W:  mis = (addr_lo != 2'b00);
      SIZE_H:  mis = addr_lo[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane steering / byte enables and load extraction / extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  mask_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        ld_sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  dbe_o,
  output logic [31:0] dwdata_o,
  output logic [31:0] ld_data_o
);

  size_e       size;
  logic [31:0] shifted;

  always_comb begin
    size      = decode_size(mask_i);
    shifted   = rdata_i >> {addr_lo_i, 3'b000};
    dbe_o     = MASK_W;
    dwdata_o  = wdata_i;
    ld_data_o = shifted;
    unique case (size)
      SIZE_B: begin
        dbe_o     = MASK_B << addr_lo_i;
        dwdata_o  = {4{wdata_i[7:0]}};
        ld_data_o = {{24{ld_sext_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        dbe_o     = MASK_H << {addr_lo_i[1], 1'b0};
        dwdata_o  = {2{wdata_i[15:0]}};
        ld_data_o = {{16{ld_sext_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, req/gnt/rvalid bus master, load/store
// alignment, stall and forwarding outputs.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_regcData,
  input  logic [4:0]  ex_regcAddr,
  input  logic        ex_regcWr,
  input  logic [31:0] ex_memAddr,
  input  logic [31:0] ex_memData,
  input  logic        ex_readWr,
  input  logic        ex_writeWr,
  input  logic [3:0]  ex_rmask,
  input  logic [3:0]  ex_wmask,
  input  logic        ex_ld_sext,
  input  logic [31:0] ex_inst_debug,
  input  logic [31:0] ex_pc_debug,
  output logic        stall_o,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  input  logic        dgnt,
  input  logic        drvalid,
  input  logic [31:0] drdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_wr,
  output logic [31:0] inst_debug,
  output logic [31:0] pc_debug,
  output logic        fwd_regWr,
  output logic [4:0]  fwd_regAddr,
  output logic [31:0] fwd_data,
  output logic        fwd_load_busy,
  output logic        adel,
  output logic        ades
);

  state_e      state_q, state_d;
  pipe_t       pipe_q, pipe_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] ld_data;
  logic [3:0]  ex_mask, mask_q;
  logic        ex_mis, exc, idle;

  mem_align u_align (
    .mask_i    (mask_q),
    .addr_lo_i (pipe_q.mem_addr[1:0]),
    .ld_sext_i (pipe_q.ld_sext),
    .wdata_i   (pipe_q.mem_data),
    .rdata_i   (drdata),
    .dbe_o     (dbe),
    .dwdata_o  (dwdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    idle    = (state_q == S_IDLE);
    ex_mask = ex_readWr ? ex_rmask : ex_wmask;
    ex_mis  = CHECK_ALIGN && is_misaligned(decode_size(ex_mask), ex_memAddr[1:0]);
    mask_q  = pipe_q.rd ? pipe_q.rmask : pipe_q.wmask;
    exc     = CHECK_ALIGN && (pipe_q.rd | pipe_q.wr) &&
              is_misaligned(decode_size(mask_q), pipe_q.mem_addr[1:0]);
  end

  // The register only advances while no bus access is outstanding.
  always_comb begin
    pipe_d = pipe_q;
    if (idle) begin
      pipe_d.regc_data = ex_regcData;
      pipe_d.regc_addr = ex_regcAddr;
      pipe_d.regc_wr   = ex_regcWr;
      pipe_d.mem_addr  = ex_memAddr;
      pipe_d.mem_data  = ex_memData;
      pipe_d.rd        = ex_readWr;
      pipe_d.wr        = ex_writeWr;
      pipe_d.rmask     = ex_rmask;
      pipe_d.wmask     = ex_wmask;
      pipe_d.ld_sext   = ex_ld_sext;
      pipe_d.inst      = ex_inst_debug;
      pipe_d.pc        = ex_pc_debug;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    case (state_q)
      S_IDLE: begin
        if ((ex_readWr | ex_writeWr) && !ex_mis) state_d = S_REQ;
      end
      S_REQ: begin
        if (dgnt) begin
          if (pipe_q.wr) begin
            state_d = S_IDLE;
          end else if (drvalid) begin
            ld_d    = ld_data;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (drvalid) begin
          ld_d    = ld_data;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pipe_q  <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      ld_q    <= ld_d;
    end
  end

  assign stall_o       = ~idle;
  assign dreq          = (state_q == S_REQ);
  assign dwe           = dreq & pipe_q.wr;
  assign daddr         = {pipe_q.mem_addr[31:2], 2'b00};
  assign wb_data       = pipe_q.rd ? ld_q : pipe_q.regc_data;
  assign wb_addr       = pipe_q.regc_addr;
  assign wb_wr         = pipe_q.regc_wr & idle & ~exc;
  assign inst_debug    = pipe_q.inst;
  assign pc_debug      = pipe_q.pc;
  assign fwd_regWr     = pipe_q.regc_wr;
  assign fwd_regAddr   = pipe_q.regc_addr;
  assign fwd_data      = wb_data;
  assign fwd_load_busy = pipe_q.rd & ~idle;
  assign adel          = idle & exc & pipe_q.rd;
  assign ades          = idle & exc & pipe_q.wr;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops, a configurable bus responder, and a
// monitor that checks write-backs, bus grants and exceptions against queued expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_regcData, ex_memAddr, ex_memData, ex_inst_debug, ex_pc_debug;
  logic [4:0]  ex_regcAddr;
  logic        ex_regcWr, ex_readWr, ex_writeWr, ex_ld_sext;
  logic [3:0]  ex_rmask, ex_wmask;
  logic        stall_o, dreq, dwe, dgnt, drvalid, wb_wr, fwd_regWr, fwd_load_busy, adel, ades;
  logic [31:0] daddr, dwdata, drdata, wb_data, inst_debug, pc_debug, fwd_data;
  logic [3:0]  dbe;
  logic [4:0]  wb_addr, fwd_regAddr;

  always #5 clk = ~clk;

  mem_stage #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ex_regcData(ex_regcData), .ex_regcAddr(ex_regcAddr), .ex_regcWr(ex_regcWr),
    .ex_memAddr(ex_memAddr), .ex_memData(ex_memData), .ex_readWr(ex_readWr),
    .ex_writeWr(ex_writeWr), .ex_rmask(ex_rmask), .ex_wmask(ex_wmask),
    .ex_ld_sext(ex_ld_sext), .ex_inst_debug(ex_inst_debug), .ex_pc_debug(ex_pc_debug),
    .stall_o(stall_o), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dgnt(dgnt), .drvalid(drvalid), .drdata(drdata),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_wr(wb_wr),
    .inst_debug(inst_debug), .pc_debug(pc_debug),
    .fwd_regWr(fwd_regWr), .fwd_regAddr(fwd_regAddr), .fwd_data(fwd_data),
    .fwd_load_busy(fwd_load_busy), .adel(adel), .ades(ades)
  );

  typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wd;} bus_t;

  wb_t        wb_q[$];
  bus_t       bus_q[$];
  logic [1:0] exc_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          gnt_wait = 0;
  int          rv_wait = 0;
  logic [31:0] rdat = '0;
  logic [31:0] cur_inst, cur_pc;
  logic [4:0]  cur_rd;
  int          op_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd; e.data = data;
    wb_q.push_back(e);
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    bus_t e;
    e.addr = addr; e.we = we; e.be = be; e.wd = wd;
    bus_q.push_back(e);
  endtask

  // Monitor: compares every presented DUT event against the head of its queue.
  initial begin
    wb_t  w;
    bus_t b;
    logic [1:0] x;
    forever begin
      @(negedge clk);
      if (wb_wr === 1'b1) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_spurious: got r%0d=%h expected no write-back", wb_addr, wb_data);
        end else begin
          w = wb_q.pop_front();
          check("wb_addr", {27'b0, wb_addr}, {27'b0, w.rd});
          check("wb_data", wb_data, w.data);
        end
      end
      if (dreq === 1'b1 && dgnt === 1'b1) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_spurious: got daddr=%h dwe=%b expected no access", daddr, dwe);
        end else begin
          b = bus_q.pop_front();
          check("bus_daddr", daddr, b.addr);
          check("bus_dwe", {31'b0, dwe}, {31'b0, b.we});
          if (b.we) begin
            check("bus_dbe", {28'b0, dbe}, {28'b0, b.be});
            check("bus_dwdata", dwdata, b.wd);
          end
        end
      end
      if (adel === 1'b1 || ades === 1'b1) begin
        if (exc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL exc_spurious: got adel=%b ades=%b expected none", adel, ades);
        end else begin
          x = exc_q.pop_front();
          check("exc_adel_ades", {30'b0, adel, ades}, {30'b0, x});
        end
      end
    end
  end

  // Bus slave: dgnt after gnt_wait request cycles, rvalid rv_wait cycles after gnt.
  initial begin
    int cnt = 0;
    int rcnt = 0;
    bit pend = 1'b0;
    dgnt = 1'b0; drvalid = 1'b0; drdata = '0;
    forever begin
      @(posedge clk);
      #1;
      dgnt = 1'b0; drvalid = 1'b0;
      if (rst) begin
        cnt = 0; rcnt = 0; pend = 1'b0;
      end else if (dreq) begin
        if (cnt < gnt_wait) begin
          cnt++;
        end else begin
          cnt = 0; dgnt = 1'b1;
          if (!dwe) begin
            if (rv_wait == 0) begin drvalid = 1'b1; drdata = rdat; end
            else pend = 1'b1;
          end
        end
      end else if (pend) begin
        rcnt++;
        if (rcnt >= rv_wait) begin
          drvalid = 1'b1; drdata = rdat; pend = 1'b0; rcnt = 0;
        end
      end
    end
  end

  task automatic bubble();
    ex_regcData = '0; ex_regcAddr = '0; ex_regcWr = 1'b0; ex_memAddr = '0; ex_memData = '0;
    ex_readWr = 1'b0; ex_writeWr = 1'b0; ex_rmask = '0; ex_wmask = '0; ex_ld_sext = 1'b0;
    ex_inst_debug = '0; ex_pc_debug = '0;
  endtask

  // Presents one op for exactly one capture edge, then returns a bubble.
  task automatic drive(input logic [31:0] data, input logic [4:0] rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic ld,
                       input logic st, input logic [3:0] mask, input logic sext);
    op_idx++;
    cur_inst = 32'h0000_1000 + op_idx;
    cur_pc   = 32'hBFC0_0000 + 4 * op_idx;
    cur_rd   = rd;
    ex_regcData = data; ex_regcAddr = rd; ex_regcWr = wr; ex_memAddr = addr;
    ex_memData = sdata; ex_readWr = ld; ex_writeWr = st; ex_rmask = mask; ex_wmask = mask;
    ex_ld_sext = sext; ex_inst_debug = cur_inst; ex_pc_debug = cur_pc;
    @(posedge clk);
    #1;
    bubble();
  endtask

  task automatic finish_op(input string name, input int exp_stall, input logic exp_busy);
    int n = 0;
    @(negedge clk);
    check({name, "_fwd_busy"}, {31'b0, fwd_load_busy}, {31'b0, exp_busy});
    check({name, "_fwd_addr"}, {27'b0, fwd_regAddr}, {27'b0, cur_rd});
    check({name, "_inst"}, inst_debug, cur_inst);
    check({name, "_pc"}, pc_debug, cur_pc);
    while (stall_o === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stall"}, n, exp_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_dreq", {31'b0, dreq}, 32'h0);
    check("rst_wb_wr", {31'b0, wb_wr}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_addr", {27'b0, wb_addr}, 32'h0);
    check("rst_fwd_busy", {31'b0, fwd_load_busy}, 32'h0);
    check("rst_exc", {30'b0, adel, ades}, 32'h0);
    check("rst_inst", inst_debug, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    exp_wb(5'd5, 32'h0000_1234);
    drive(32'h1234, 5'd5, 1'b1, '0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    finish_op("add", 0, 1'b0);

    gnt_wait = 2;
    exp_bus(32'h100, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    drive('0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 1'b0);
    finish_op("sw", 3, 1'b0);

    gnt_wait = 0; rv_wait = 2; rdat = 32'h80FF_FFFF;
    exp_bus(32'h200, 1'b0, 4'b0000, '0);
    exp_wb(5'd7, 32'hFFFF_FF80);
    drive(32'h0000_DEAD, 5'd7, 1'b1, 32'h203, '0, 1'b1, 1'b0, 4'b0001, 1'b1);
    finish_op("lb", 3, 1'b1);

    exp_bus(32'h200, 1'b0, 4'b0000, '0);
    exp_wb(5'd8, 32'h0000_0080);
    drive('0, 5'd8, 1'b1, 32'h203, '0, 1'b1, 1'b0, 4'b0001, 1'b0);
    finish_op("lbu", 3, 1'b1);

    rv_wait = 0;
    exp_bus(32'h300, 1'b1, 4'b1100, 32'hABCD_ABCD);
    drive('0, 5'd0, 1'b0, 32'h302, 32'h1234_ABCD, 1'b0, 1'b1, 4'b0011, 1'b0);
    finish_op("sh", 1, 1'b0);

    exc_q.push_back(2'b10);
    drive('0, 5'd9, 1'b1, 32'h301, '0, 1'b1, 1'b0, 4'b0011, 1'b1);
    finish_op("lh_mis", 0, 1'b0);

    exc_q.push_back(2'b01);
    drive('0, 5'd0, 1'b0, 32'h102, 32'h1111_2222, 1'b0, 1'b1, 4'b1111, 1'b0);
    finish_op("sw_mis", 0, 1'b0);

    rdat = 32'h55AA_55AA;
    exp_bus(32'h400, 1'b0, 4'b0000, '0);
    exp_wb(5'd10, 32'h55AA_55AA);
    drive('0, 5'd10, 1'b1, 32'h400, '0, 1'b1, 1'b0, 4'b1111, 1'b0);
    finish_op("lw", 1, 1'b1);

    gnt_wait = 1; rv_wait = 1; rdat = 32'h8001_1234;
    exp_bus(32'h400, 1'b0, 4'b0000, '0);
    exp_wb(5'd11, 32'hFFFF_8001);
    drive('0, 5'd11, 1'b1, 32'h402, '0, 1'b1, 1'b0, 4'b0011, 1'b1);
    finish_op("lh", 3, 1'b1);

    gnt_wait = 0; rv_wait = 0;
    exp_wb(5'd12, 32'hCAFE_F00D);
    drive(32'hCAFE_F00D, 5'd12, 1'b1, '0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    finish_op("add2", 0, 1'b0);

    exp_bus(32'h400, 1'b1, 4'b0010, 32'h5A5A_5A5A);
    drive('0, 5'd0, 1'b0, 32'h401, 32'h1234_565A, 1'b0, 1'b1, 4'b0001, 1'b0);
    finish_op("sb", 1, 1'b0);

    exp_bus(32'h500, 1'b1, 4'b1111, 32'h0123_4567);
    drive('0, 5'd0, 1'b0, 32'h500, 32'h0123_4567, 1'b0, 1'b1, 4'b0111, 1'b0);
    finish_op("sw_oddmask", 1, 1'b0);

    // Reset while the load waits for rvalid: the load must never retire.
    rv_wait = 10; rdat = 32'h1111_1111;
    exp_bus(32'h600, 1'b0, 4'b0000, '0);
    drive('0, 5'd13, 1'b1, 32'h600, '0, 1'b1, 1'b0, 4'b1111, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("wait_stall_pre", {31'b0, stall_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("wait_rst_dreq", {31'b0, dreq}, 32'h0);
    check("wait_rst_stall", {31'b0, stall_o}, 32'h0);
    check("wait_rst_wb_wr", {31'b0, wb_wr}, 32'h0);
    check("wait_rst_busy", {31'b0, fwd_load_busy}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    rv_wait = 0;
    exp_wb(5'd3, 32'h0000_0077);
    drive(32'h77, 5'd3, 1'b1, '0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    finish_op("add_after_rst", 0, 1'b0);

    // Reset while a store is still requesting: dreq must drop without a clock edge.
    gnt_wait = 20;
    drive('0, 5'd0, 1'b0, 32'h700, 32'h7777_7777, 1'b0, 1'b1, 4'b1111, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("req_dreq_pre", {31'b0, dreq}, 32'h1);
    rst = 1'b1;
    #1;
    check("req_rst_dreq", {31'b0, dreq}, 32'h0);
    check("req_rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    gnt_wait = 0;
    exp_wb(5'd4, 32'h0000_0099);
    drive(32'h99, 5'd4, 1'b1, '0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    finish_op("add_after_rst2", 0, 1'b0);

    repeat (3) @(posedge clk);
    check("wb_q_drained", wb_q.size(), 32'h0);
    check("bus_q_drained", bus_q.size(), 32'h0);
    check("exc_q_drained", exc_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
